sync_ram_bytewr: RTL and testbench
==================================

// Module: sync_ram_bytewr
// PURPOSE
//  Parametrised single-port synchronous RAM. Successor to the fixed 64x32 memory.
//  Adds per-byte write enables, a registered read with a valid strobe, and out-of-range detection.
//  A hardware clear engine zeroes every word after reset or on request.
//  Sits as local scratch storage behind a simple request interface; no backpressure.
// PARAMETERS
//  DATA_W  32  word width in bits; must be a multiple of 8
//  DEPTH   64  number of words; need not be a power of two
//  ADDR_W   8  address width; DEPTH <= 2**ADDR_W
// PORTS
//  clk           in   1         single clock, all logic on rising edge
//  rst_n         in   1         synchronous, active-low reset
//  write_enable  in   1         write request this cycle
//  read_enable   in   1         read request this cycle
//  byte_en       in   DATA_W/8  per-byte write lane enables (bit k -> data_in[8k+7:8k])
//  address       in   ADDR_W    word address for read/write
//  data_in       in   DATA_W    write data
//  clear         in   1         pulse: start zeroing the whole array
//  data_out      out  DATA_W    registered read data
//  valid_out     out  1         1-cycle strobe: data_out holds a new read result
//  addr_err      out  1         1-cycle strobe: last request had address >= DEPTH
//  parity_err    out  1         1-cycle strobe with valid_out on parity mismatch
//  busy          out  1         1 while the clear engine runs; requests ignored
// BEHAVIOUR
//  Reset (rst_n=0 at edge): data_out=0, valid_out=0, addr_err=0, parity_err=0, busy=1, clr_ptr=0, FSM=CLEAR.
//  FSM states:
//   - CLEAR: write 0 (and matching parity) to word clr_ptr; clr_ptr++ each cycle.
//     After word DEPTH-1 is written -> IDLE; busy falls in the same edge.
//     A clear always lasts exactly DEPTH cycles.
//   - IDLE: service requests; clear=1 -> CLEAR with clr_ptr=0, and busy=1 from the next cycle.
//  CLEAR restrictions:
//   - write_enable, read_enable and clear are ignored.
//   - valid_out and addr_err stay 0.
//  Write (IDLE, write_enable=1, address<DEPTH):
//   - lanes with byte_en[k]=1 update at the edge; other lanes keep their old value.
//   - byte_en=0 is a legal no-op.
//  Read (IDLE, read_enable=1, address<DEPTH):
//   - latency 1: data_out and valid_out=1 appear after the next edge.
//   - data_out holds its value until the next read; it does not return to 0.
//  Read+write to the same address in the same cycle: read-first. data_out returns pre-write data; the write still lands.
//  Out of range (address>=DEPTH, with write_enable or read_enable):
//   - the write is dropped.
//   - a read gives data_out=0 with valid_out=1.
//   - addr_err=1 for one cycle.
//  clear together with write_enable/read_enable in IDLE: clear wins; the request is dropped.
//  rst_n low mid-clear or mid-read: restarts the clear from word 0; a pending valid_out is squashed.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//   - each byte stores one extra even-parity bit, written with its lane.
//   - on read, recompute parity per byte; parity_err=1 with valid_out if any byte mismatches.
//   - out-of-range reads never flag parity_err.
//  MEM_PARITY_EN undefined:
//   - no parity storage; parity_err is tied to 0.
//   - the port list is unchanged.
// TESTING
//  1. Release rst_n -> busy=1 for exactly 64 cycles. Then read addr 0..63 -> all data_out=0, valid_out=1 each cycle after.
//  2. Write addr 5 data 0xAABBCCDD byte_en=4'b1111, then 0x11223344 byte_en=4'b0101 -> read addr 5 = 0xAA22CC44.
//  3. Same cycle: write addr 9 = 0xDEADBEEF and read addr 9 (held 0x0) -> data_out=0x0; next read addr 9 = 0xDEADBEEF.
//  4. Write addr 200 = 0x12345678 -> addr_err pulse, nothing stored. Read addr 200 -> data_out=0, valid_out=1, addr_err=1.
//  5. Fill data, pulse clear, drive reads during busy -> valid_out stays 0 for 64 cycles. Then all reads return 0.
//     Assert rst_n=0 at clear cycle 30 -> busy stays high for a full 64 cycles after release.
//  6. With MEM_PARITY_EN: force one stored parity bit via hierarchical poke, read that word -> parity_err=1 with valid_out.
//     Without the macro -> parity_err=0 throughout.

Source files
------------

// File: rtl/sync_ram_bytewr.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_bytewr
//  Description : Single-port synchronous RAM with byte-lane writes, registered
//                read plus valid strobe, range checking and a clear engine.
//                Optional per-byte even parity when MEM_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_bytewr #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_enable,
    input  logic                read_enable,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                clear,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    output logic                addr_err,
    output logic                parity_err,
    output logic                busy
);

    localparam int                c_NB       = DATA_W / 8;
    localparam int                c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_IDLE  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_clr_ptr;
    logic [ADDR_W-1:0]  w_clr_ptr_nxt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_data_out;
    logic               r_valid_out;
    logic               r_addr_err;

    logic               w_accept;
    logic               w_in_range;
    logic               w_wr;
    logic               w_rd;
    logic               w_clr_wr;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_clr_idx;

    // A clear request in IDLE pre-empts any read/write presented with it.
    assign w_accept   = (r_state == c_ST_IDLE) && !clear;
    assign w_in_range = ({1'b0, address} < c_DEPTH);
    assign w_wr       = w_accept && write_enable && w_in_range;
    assign w_rd       = w_accept && read_enable;
    assign w_clr_wr   = (r_state == c_ST_CLEAR);
    assign w_idx      = address[c_IDX_W-1:0];
    assign w_clr_idx  = r_clr_ptr[c_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            c_ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                if (clear) begin
                    w_state_nxt   = c_ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_wr) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_wr) begin
                for (int k = 0; k < c_NB; k++) begin
                    if (byte_en[k]) begin
                        r_mem[w_idx][8*k +: 8] <= data_in[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read-first: the registered read samples the array before this edge's write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_valid_out <= w_rd;
            r_addr_err  <= w_accept && (write_enable || read_enable) && !w_in_range;
            if (w_rd) begin
                r_data_out <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign addr_err  = r_addr_err;
    assign busy      = (r_state == c_ST_CLEAR);

`ifdef MEM_PARITY_EN
    logic [c_NB-1:0] r_par [DEPTH];
    logic [c_NB-1:0] w_par_in;
    logic [c_NB-1:0] w_par_chk;
    logic            r_parity_err;

    for (genvar k = 0; k < c_NB; k++) begin : g_par
        assign w_par_in[k]  = ^data_in[8*k +: 8];
        assign w_par_chk[k] = (^r_mem[w_idx][8*k +: 8]) ^ r_par[w_idx][k];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_wr) begin
                r_par[w_clr_idx] <= '0;
            end else if (w_wr) begin
                for (int k = 0; k < c_NB; k++) begin
                    if (byte_en[k]) begin
                        r_par[w_idx][k] <= w_par_in[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_rd && w_in_range && (|w_par_chk);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_bytewr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_bytewr
//  Description : Randomised self-checking bench for sync_ram_bytewr against a
//                word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram_bytewr;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 8;
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              write_enable;
    logic              read_enable;
    logic [NB-1:0]     byte_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clear;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              addr_err;
    logic              parity_err;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_valid;
    logic              exp_err;

    always #5 clk = ~clk;

    sync_ram_bytewr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .byte_en      (byte_en),
        .address      (address),
        .data_in      (data_in),
        .clear        (clear),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .addr_err     (addr_err),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
        byte_en      = '0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One request cycle; expected outputs come from the word-array model.
    task automatic op(input logic we, input logic re, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_in      = d;
        byte_en      = be;
        clear        = 1'b0;
        exp_valid    = re;
        exp_err      = (we || re) && (int'(a) >= DEPTH);
        if (re) exp_dout = (int'(a) < DEPTH) ? model[a] : '0;
        if (we && int'(a) < DEPTH) begin
            for (int k = 0; k < NB; k++)
                if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
        end
        step();
        idle_inputs();
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        read_enable = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_valid_in_clear cycle=%0d got=%b exp=0", name, n, valid_out);
            end
            address = 8'($urandom_range(0, 255));
            step();
            n++;
        end
        idle_inputs();
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL %s_busy_len got=%0d exp=%0d", name, n, DEPTH);
        end
        model_zero();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        address = '0;
        data_in = '0;
        idle_inputs();
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", data_out); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        exp_dout = '0;
        rst_n = 1'b1;
        wait_clear_done("reset");
    endtask

    task automatic test_read_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 1'b1, 8'(i), '0, '0);
            checks++;
            if (valid_out !== 1'b1 || data_out !== model[i]) begin
                errors++;
                $display("FAIL %s_rd[%0d] got=%h/%b exp=%h/1", name, i, data_out, valid_out, model[i]);
            end
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || data_out !== exp_dout) begin
            errors++;
            $display("FAIL %s_hold got=%h/%b exp=%h/0", name, data_out, valid_out, exp_dout);
        end
    endtask

    task automatic test_byte_write();
        op(1'b1, 1'b0, 8'd5, 32'hAABBCCDD, 4'b1111);
        op(1'b1, 1'b0, 8'd5, 32'h11223344, 4'b0101);
        op(1'b1, 1'b0, 8'd5, 32'h55667788, 4'b0000);
        op(1'b0, 1'b1, 8'd5, '0, '0);
        checks++;
        if (data_out !== 32'hAA22CC44 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL byte_write got=%h/%b exp=aa22cc44/1", data_out, valid_out);
        end
    endtask

    task automatic test_rw_same();
        op(1'b1, 1'b1, 8'd9, 32'hDEADBEEF, 4'b1111);
        checks++;
        if (data_out !== 32'h0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL rw_same_first got=%h/%b exp=0/1", data_out, valid_out);
        end
        op(1'b0, 1'b1, 8'd9, '0, '0);
        checks++;
        if (data_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rw_same_second got=%h exp=deadbeef", data_out);
        end
    endtask

    task automatic test_out_of_range();
        op(1'b1, 1'b0, 8'd200, 32'h12345678, 4'b1111);
        checks++;
        if (addr_err !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr got=%b/%b exp=1/0", addr_err, valid_out);
        end
        step();
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_pulse got=%b exp=0", addr_err); end
        op(1'b0, 1'b1, 8'd200, '0, '0);
        checks++;
        if (data_out !== 32'h0 || valid_out !== 1'b1 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd got=%h/%b/%b exp=0/1/1", data_out, valid_out, addr_err);
        end
        // 200 mod 64 = 8: the dropped write must not alias onto word 8.
        op(1'b0, 1'b1, 8'd8, '0, '0);
        checks++;
        if (data_out !== model[8] || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_alias got=%h/%b exp=%h/0", data_out, addr_err, model[8]);
        end
    endtask

    task automatic test_random(input int n_ops);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n_ops; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(DEPTH, 255))
                                            : 8'($urandom_range(0, DEPTH - 1));
            op(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
            checks++;
            if (data_out !== exp_dout || valid_out !== exp_valid ||
                addr_err !== exp_err || parity_err !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] got=%h/%b/%b/%b exp=%h/%b/%b/0", i,
                         data_out, valid_out, addr_err, parity_err, exp_dout, exp_valid, exp_err);
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'(i), $urandom | 32'h1, 4'b1111);
        op(1'b0, 1'b1, 8'd3, '0, '0);
        clear = 1'b1;
        read_enable = 1'b1;
        write_enable = 1'b1;
        byte_en = 4'b1111;
        address = 8'd3;
        data_in = $urandom;
        step();
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (busy !== 1'b1 || valid_out !== 1'b0 || addr_err !== 1'b0 || data_out !== exp_dout) begin
                errors++;
                $display("FAIL clear_busy[%0d] got=%b/%b/%b/%h exp=1/0/0/%h", i,
                         busy, valid_out, addr_err, data_out, exp_dout);
            end
            address = 8'($urandom_range(0, 255));
            data_in = $urandom;
            step();
        end
        idle_inputs();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_end got=%b exp=0", busy); end
        model_zero();
        test_read_all("after_clear");

        op(1'b1, 1'b0, 8'd40, 32'hCAFEF00D, 4'b1111);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (30) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || valid_out !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL midclear_reset got=%b/%b/%h exp=1/0/0", busy, valid_out, data_out);
        end
        exp_dout = '0;
        rst_n = 1'b1;
        wait_clear_done("midclear");
        op(1'b0, 1'b1, 8'd40, '0, '0);
        checks++;
        if (data_out !== 32'h0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL midclear_rd got=%h/%b exp=0/1", data_out, valid_out);
        end
    endtask

    task automatic test_parity();
        logic exp_perr;
        op(1'b1, 1'b0, 8'd7, 32'h0F0F1234, 4'b1111);
        op(1'b1, 1'b0, 8'd8, 32'h89ABCDEF, 4'b1111);
`ifdef MEM_PARITY_EN
        dut.r_par[7][0] <= ~dut.r_par[7][0];
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        #1;
        op(1'b0, 1'b1, 8'd7, '0, '0);
        checks++;
        if (parity_err !== exp_perr || valid_out !== 1'b1 || data_out !== 32'h0F0F1234) begin
            errors++;
            $display("FAIL parity_rd got=%b/%b/%h exp=%b/1/0f0f1234", parity_err, valid_out, data_out, exp_perr);
        end
        op(1'b0, 1'b1, 8'd8, '0, '0);
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got=%b exp=0", parity_err); end
        op(1'b0, 1'b1, 8'd71, '0, '0);
        checks++;
        if (parity_err !== 1'b0 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_oor got=%b/%b exp=0/1", parity_err, addr_err);
        end
    endtask

    initial begin
        test_reset();
        test_read_all("init");
        test_byte_write();
        test_rw_same();
        test_out_of_range();
        test_random(300);
        test_clear();
        test_random(100);
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
